// File: rtl/bsg_fifo_to_packet_gearbox_if.sv
// Host-word / network-packet handshake bundle for the fifo-to-packet gearbox.
// The slave modport is the gearbox side. The master modport is the host/network side.
interface bsg_fifo_to_packet_gearbox_if #(
  parameter int addr_width_p   = 32,
  parameter int data_width_p   = 32,
  parameter int packet_width_p = 128
);
  logic                      v_i;
  logic [addr_width_p-1:0]   addr_i;
  logic [data_width_p-1:0]   data_i;
  logic                      yumi_o;
  logic                      pkt_v_o;
  logic [packet_width_p-1:0] pkt_data_o;
  logic                      pkt_ready_i;
  logic                      pkt_v_i;
  logic [packet_width_p-1:0] pkt_data_i;
  logic                      pkt_ready_o;
  logic                      v_o;
  logic [data_width_p-1:0]   data_o;
  logic                      ready_i;

  modport slave (
    input  v_i, addr_i, data_i, pkt_ready_i, pkt_v_i, pkt_data_i, ready_i,
    output yumi_o, pkt_v_o, pkt_data_o, pkt_ready_o, v_o, data_o
  );

  modport master (
    output v_i, addr_i, data_i, pkt_ready_i, pkt_v_i, pkt_data_i, ready_i,
    input  yumi_o, pkt_v_o, pkt_data_o, pkt_ready_o, v_o, data_o
  );
endinterface

// File: rtl/bsg_fifo_to_packet_gearbox.sv
// Gathers host data words into one wide network packet and serializes return
// packets back into host data words. The two directions share no state.
module bsg_fifo_to_packet_gearbox #(
  parameter int addr_width_p   = 32,
  parameter int data_width_p   = 32,
  parameter int packet_width_p = 128
) (
  input logic                          clk_i,
  input logic                          reset_n_i,
  bsg_fifo_to_packet_gearbox_if.slave  io
);
  localparam int els_lp   = (packet_width_p + data_width_p - 1) / data_width_p;
  localparam int cnt_w_lp = (els_lp > 1) ? $clog2(els_lp) : 1;
  localparam int buf_w_lp = els_lp * data_width_p;

  typedef enum logic { WR_FILL, WR_FULL } wr_state_e;
  typedef enum logic { RD_IDLE, RD_SEND } rd_state_e;

  wr_state_e            wr_state, wr_state_n;
  rd_state_e            rd_state, rd_state_n;
  logic [cnt_w_lp-1:0]  fill_cnt;
  logic [buf_w_lp-1:0]  acc;
  logic [cnt_w_lp-1:0]  rd_idx;
  logic [buf_w_lp-1:0]  rd_buf;
  logic [buf_w_lp-1:0]  pkt_ext;
  logic                 is_payload, is_clear, last_slot, last_word;
  logic                 wr_take, rd_load, rd_shift;

  assign is_payload = (io.addr_i != '0);
  assign is_clear   = !is_payload && io.data_i[0];
  assign last_slot  = (fill_cnt == cnt_w_lp'(els_lp - 1));
  assign last_word  = (rd_idx == cnt_w_lp'(els_lp - 1));

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    wr_state_n     = wr_state;
    rd_state_n     = rd_state;
    wr_take        = 1'b0;
    rd_load        = 1'b0;
    rd_shift       = 1'b0;
    io.yumi_o      = 1'b0;
    io.pkt_v_o     = 1'b0;
    io.pkt_ready_o = 1'b0;
    io.v_o         = 1'b0;
    pkt_ext        = '0;
    pkt_ext[packet_width_p-1:0] = io.pkt_data_i;

    unique case (wr_state)
      WR_FILL: begin
        io.yumi_o = io.v_i;
        wr_take   = io.v_i;
        if (io.v_i && is_payload && last_slot) wr_state_n = WR_FULL;
      end
      WR_FULL: begin
        io.pkt_v_o = 1'b1;
        if (io.pkt_ready_i) wr_state_n = WR_FILL;
      end
      default: wr_state_n = WR_FILL;
    endcase

    unique case (rd_state)
      RD_IDLE: begin
        io.pkt_ready_o = 1'b1;
        rd_load        = io.pkt_v_i;
        if (io.pkt_v_i) rd_state_n = RD_SEND;
      end
      RD_SEND: begin
        io.v_o   = 1'b1;
        rd_shift = io.ready_i;
        if (io.ready_i && last_word) rd_state_n = RD_IDLE;
      end
      default: rd_state_n = RD_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_state <= WR_FILL;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_state_n;
      rd_state <= rd_state_n;
    end
  end

  // Payload words land in their slot; a clear control word wipes the partial packet.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fill_cnt <= '0;
      acc      <= '0;
    end else if (wr_take) begin
      if (is_payload) begin
        acc[fill_cnt*data_width_p +: data_width_p] <= io.data_i;
        fill_cnt <= last_slot ? '0 : fill_cnt + cnt_w_lp'(1);
      end else if (is_clear) begin
        fill_cnt <= '0;
        acc      <= '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)    rd_idx <= '0;
    else if (rd_load)  rd_idx <= '0;
    else if (rd_shift) rd_idx <= rd_idx + cnt_w_lp'(1);
  end

  // NOTE: the return buffer is left out of reset on purpose; v_o gates it and every load overwrites it fully.
  always_ff @(posedge clk_i) begin
    if (rd_load)       rd_buf <= pkt_ext;
    else if (rd_shift) rd_buf <= rd_buf >> data_width_p;
  end

  assign io.pkt_data_o = acc[packet_width_p-1:0];
  assign io.data_o     = rd_buf[data_width_p-1:0];
endmodule
